// File: rtl/j1_uart_rx_pkg.sv
// Shared definitions for the j1soc UART receiver: bus offsets, STATUS bits, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package j1_uart_rx_pkg;

    // Register offsets on the J1 I/O bus
    localparam logic [1:0] UART_RX_DATA = 2'd0;
    localparam logic [1:0] UART_RX_STAT = 2'd1;

    // STATUS bit positions; bits [7:4] carry the FIFO count
    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVR    = 2;
    localparam int ST_FERR   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/j1_uart_rx_fifo.sv
// Synchronous byte FIFO, DEPTH a power of 2; head is visible combinationally on dout.
// Latency: a pushed byte is readable the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module j1_uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A pop frees the slot the simultaneous push lands in, so full+pop still accepts
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/j1_uart_rx.sv
// 8N1 serial receiver with byte FIFO and memory-mapped DATA/STATUS registers for the J1 core.
// Latency: byte enters FIFO one cycle after stop-bit sample; bus reads return on the next edge.
// Backpressure: none on the line; a byte arriving at a full FIFO is dropped and flags OVR.
module j1_uart_rx
    import j1_uart_rx_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        uart_rx_i,
    input  logic        cs_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic [1:0]  addr_i,
    input  logic [15:0] d_in,
    output logic [15:0] d_out,
    output logic        rx_led,
    output logic        irq_o
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV/2 - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);

    logic            rx_s1, rx_s2, rx_prev;
    rx_state_t       state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_nxt;
    logic [7:0]      shreg, sh_nxt;
    logic            stop_ok, stop_bad;
    logic            push_pend;
    logic [7:0]      push_dat;
    logic            ferr, ovr;
    logic            rd_q, wr_q, pop, ovr_set, ovr_clr, ferr_clr;
    logic [7:0]      fifo_dout;
    logic            fifo_full, fifo_empty;
    logic [AW:0]     fifo_count;
    logic [7:0]      status;
    logic            unused_din;

    assign unused_din = ^{d_in[15:4], d_in[1:0]};

    // Two-stage synchroniser plus one delayed copy for edge detection; idle-high reset
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // FSM, baud counter, bit index and shift register state
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= sh_nxt;
        end
    end

    // Next-state logic: half-bit recheck of start, then full-bit spacing for data and stop
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (rx_prev && !rx_s2) state_nxt = S_START;
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rx_s2, shreg[7:1]};
                    bit_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                    stop_ok   = rx_s2;
                    stop_bad  = !rx_s2;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage the completed byte so it lands in the FIFO one cycle after the stop sample
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            push_pend <= 1'b0;
            push_dat  <= '0;
        end else begin
            push_pend <= stop_ok;
            if (stop_ok) push_dat <= shreg;
        end
    end

    assign rd_q     = cs_i && rd_i;
    assign wr_q     = cs_i && wr_i;
    assign pop      = rd_q && (addr_i == UART_RX_DATA);
    assign ovr_set  = push_pend && fifo_full && !pop;
    assign ovr_clr  = wr_q && (addr_i == UART_RX_STAT) && d_in[2];
    assign ferr_clr = wr_q && (addr_i == UART_RX_STAT) && d_in[3];

    j1_uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (sys_clk_i),
        .rst   (sys_rst_i),
        .push  (push_pend),
        .pop   (pop),
        .din   (push_dat),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= ovr_set  || (ovr  && !ovr_clr);
            ferr <= stop_bad || (ferr && !ferr_clr);
        end
    end

    // STATUS word assembly
    always_comb begin
        status            = '0;
        status[7:4]       = 4'(fifo_count);
        status[ST_FERR]   = ferr;
        status[ST_OVR]    = ovr;
        status[ST_FULL]   = fifo_full;
        status[ST_NEMPTY] = !fifo_empty;
    end

    // Registered read port; holds its value between qualified reads
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            d_out <= '0;
        end else if (rd_q) begin
            case (addr_i)
                UART_RX_DATA: d_out <= fifo_empty ? 16'h0000 : {8'h00, fifo_dout};
                UART_RX_STAT: d_out <= {8'h00, status};
                default:      d_out <= 16'h0000;
            endcase
        end
    end

    assign rx_led = (state != S_IDLE);
    assign irq_o  = !fifo_empty;

endmodule

// File: tb/tb_j1_uart_rx.sv
// Directed bench for j1_uart_rx: serial frames, glitch, framing error, overflow, reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_j1_uart_rx;
    localparam int DIV   = 434;
    localparam int FRAME = 10 * DIV + 20;

    logic        clk;
    logic        rst;
    logic        line;
    logic        cs, rd, wr;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] d_out;
    logic        rx_led;
    logic        irq;

    int n_assert;
    int n_fail;
    int led_cycles;
    logic [15:0] v;

    j1_uart_rx #(.CLK_HZ(50_000_000), .BAUD(115200), .FIFO_DEPTH(8)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .uart_rx_i (line),
        .cs_i      (cs),
        .rd_i      (rd),
        .wr_i      (wr),
        .addr_i    (addr),
        .d_in      (din),
        .d_out     (d_out),
        .rx_led    (rx_led),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] val);
        cs = 1'b1; rd = 1'b1; addr = a;
        tick();
        cs = 1'b0; rd = 1'b0;
        val = d_out;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] dat);
        cs = 1'b1; wr = 1'b1; addr = a; din = dat;
        tick();
        cs = 1'b0; wr = 1'b0; din = '0;
    endtask

    // Drives a frame bit-serially for ncyc cycles; optional DATA read strobe at cycle rd_at
    task automatic send(input logic [7:0] b, input logic stop, input int ncyc, input int rd_at);
        logic [9:0] f;
        int k;
        f = {stop, b, 1'b0};
        led_cycles = 0;
        for (int c = 0; c < ncyc; c++) begin
            k = c / DIV;
            line = (k < 10) ? f[k[3:0]] : 1'b1;
            if (c == rd_at) begin
                cs = 1'b1; rd = 1'b1; addr = 2'd0;
            end else begin
                cs = 1'b0; rd = 1'b0;
            end
            tick();
            if (rx_led) led_cycles++;
        end
        line = 1'b1; cs = 1'b0; rd = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        line = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_dout", d_out, 16'h0000);
        chk("rst_led", {15'd0, rx_led}, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        rst = 1'b0;
        repeat (5) tick();
        bus_read(2'd1, v); chk("rst_status", v, 16'h0000);

        // 1: clean frame 0xA5
        send(8'hA5, 1'b1, FRAME, -1);
        chk("t1_led_len", {15'd0, (led_cycles >= 4113 && led_cycles <= 4133)}, 16'h0001);
        chk("t1_led_off", {15'd0, rx_led}, 16'h0000);
        chk("t1_irq", {15'd0, irq}, 16'h0001);
        bus_read(2'd1, v); chk("t1_status", v, 16'h0011);
        bus_read(2'd0, v); chk("t1_data", v, 16'h00A5);
        bus_read(2'd1, v); chk("t1_status_after", v, 16'h0000);
        chk("t1_irq_after", {15'd0, irq}, 16'h0000);

        // 2: 100-cycle low glitch is rejected at the half-bit recheck
        for (int c = 0; c < DIV/2 + 3; c++) begin
            line = (c < 100) ? 1'b0 : 1'b1;
            tick();
            if (c == 150) chk("t2_led_mid", {15'd0, rx_led}, 16'h0001);
        end
        chk("t2_led_off", {15'd0, rx_led}, 16'h0000);
        repeat (20) tick();
        bus_read(2'd1, v); chk("t2_status", v, 16'h0000);

        // 3: framing error on 0x3C, then clear FERR
        send(8'h3C, 1'b0, FRAME, -1);
        bus_read(2'd1, v); chk("t3_status", v, 16'h0008);
        chk("t3_irq", {15'd0, irq}, 16'h0000);
        bus_write(2'd1, 16'h0008);
        bus_read(2'd1, v); chk("t3_status_clr", v, 16'h0000);

        // 4: nine bytes into an eight-deep FIFO; 0x09 is dropped
        for (int b = 1; b <= 9; b++) send(8'(b), 1'b1, FRAME, -1);
        bus_read(2'd1, v); chk("t4_status", v, 16'h0087);
        bus_write(2'd1, 16'h0004);
        bus_read(2'd1, v); chk("t4_status_ovr_clr", v, 16'h0083);

        // 5: DATA read lands in the push cycle while full; push must be kept, no OVR
        send(8'h0A, 1'b1, FRAME, 4126);
        chk("t5_data_01", d_out, 16'h0001);
        bus_read(2'd1, v); chk("t5_status", v, 16'h0083);
        for (int b = 2; b <= 8; b++) begin
            bus_read(2'd0, v); chk("t5_data_seq", v, 16'(b));
        end
        bus_read(2'd1, v); chk("t5_status_one", v, 16'h0011);
        bus_read(2'd0, v); chk("t5_data_last", v, 16'h000A);

        // 6: reset during bit 3 of 0x77, then clean 0x5A
        send(8'h77, 1'b1, 2000, -1);
        chk("t6_led_mid", {15'd0, rx_led}, 16'h0001);
        rst = 1'b1;
        #1;
        chk("t6_rst_dout", d_out, 16'h0000);
        chk("t6_rst_led", {15'd0, rx_led}, 16'h0000);
        chk("t6_rst_irq", {15'd0, irq}, 16'h0000);
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        bus_read(2'd1, v); chk("t6_status_idle", v, 16'h0000);
        send(8'h5A, 1'b1, FRAME, -1);
        bus_read(2'd1, v); chk("t6_status", v, 16'h0011);
        bus_read(2'd0, v); chk("t6_data", v, 16'h005A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
